// File: rtl/aurora_link_ctrl.sv
`timescale 1ns/1ps
// aurora_link_ctrl
// Bring-up and recovery sequencer for a multi-lane Aurora link. It drives the
// core's pma_init and reset_pb in order, waits for GT PLL lock, then waits for
// all lanes plus the channel to come up. It retries a bounded number of times
// on timeout and restarts with a fresh budget when an established link drops.
//
// Optional feature macro: AURORA_LINK_STATS_EN
//   When defined, adds a 16-bit saturating link_drop_count output.
//
// Ports:
//   init_clk        in   free-running init clock (sole clock)
//   reset           in   asynchronous active-high reset
//   enable          in   level request to bring the link up (init_clk domain)
//   gt_pll_lock     in   GT PLL lock (asynchronous, synchronized here)
//   lane_up         in   per-lane up, NUM_LANES wide (user_clk domain)
//   channel_up      in   channel up (user_clk domain)
//   pma_init        out  Aurora PMA reset
//   reset_pb        out  Aurora push-button reset
//   link_ok         out  high only while LINKED
//   link_fail       out  high only while FAIL
//   retry_count     out  timeout retries consumed in the current attempt
//   state           out  FSM state encoding
//   link_drop_count out  (macro only) LINKED->PMA_HOLD transitions, saturating
module aurora_link_ctrl #(
  parameter int NUM_LANES       = 4,
  parameter int PMA_HOLD_CYCLES = 1024,
  parameter int PB_HOLD_CYCLES  = 256,
  parameter int LOCK_TIMEOUT    = 65536,
  parameter int UP_TIMEOUT      = 262144,
  parameter int MAX_RETRIES     = 3
) (
  input  logic                 init_clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 gt_pll_lock,
  input  logic [NUM_LANES-1:0] lane_up,
  input  logic                 channel_up,
  output logic                 pma_init,
  output logic                 reset_pb,
  output logic                 link_ok,
  output logic                 link_fail,
  output logic [3:0]           retry_count,
  output logic [2:0]           state
`ifdef AURORA_LINK_STATS_EN
  ,
  output logic [15:0]          link_drop_count
`endif
);

  localparam int MAX_AB = (PMA_HOLD_CYCLES > PB_HOLD_CYCLES) ? PMA_HOLD_CYCLES : PB_HOLD_CYCLES;
  localparam int MAX_CD = (LOCK_TIMEOUT > UP_TIMEOUT) ? LOCK_TIMEOUT : UP_TIMEOUT;
  localparam int MAX_T  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W  = $clog2(MAX_T) + 1;

  // The counter reads 0 in the first cycle of a state, so a state lasting N
  // cycles ends when the counter shows N-1.
  localparam logic [CNT_W-1:0] PMA_LAST  = CNT_W'(PMA_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] PB_LAST   = CNT_W'(PB_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] UP_LAST   = CNT_W'(UP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PMA_HOLD  = 3'd1,
    ST_PB_HOLD   = 3'd2,
    ST_WAIT_LOCK = 3'd3,
    ST_WAIT_UP   = 3'd4,
    ST_LINKED    = 3'd5,
    ST_RETRY     = 3'd6,
    ST_FAIL      = 3'd7
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [CNT_W-1:0]     cnt;
  logic                 lock_m, lock_s;
  logic [NUM_LANES-1:0] lane_m, lane_s;
  logic                 chan_m, chan_s;
  logic                 all_up;

  // Two-flop synchronizers for everything arriving from other clock domains.
  // lane_up is only ever consumed as an all-ones reduction held for many
  // cycles, so per-bit synchronization is sufficient.
  always_ff @(posedge init_clk or posedge reset) begin
    if (reset) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
      lane_m <= '0;
      lane_s <= '0;
      chan_m <= 1'b0;
      chan_s <= 1'b0;
    end else begin
      lock_m <= gt_pll_lock;
      lock_s <= lock_m;
      lane_m <= lane_up;
      lane_s <= lane_m;
      chan_m <= channel_up;
      chan_s <= chan_m;
    end
  end

  assign all_up = chan_s && (&lane_s);

  // Next-state decode. Dropping enable overrides everything; in the wait
  // states success is tested before the timeout so success wins a tie.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:      state_d = ST_PMA_HOLD;
        ST_PMA_HOLD:  if (cnt >= PMA_LAST) state_d = ST_PB_HOLD;
        ST_PB_HOLD:   if (cnt >= PB_LAST) state_d = ST_WAIT_LOCK;
        ST_WAIT_LOCK: begin
          if (lock_s)                 state_d = ST_WAIT_UP;
          else if (cnt >= LOCK_LAST)  state_d = ST_RETRY;
        end
        ST_WAIT_UP: begin
          if (all_up)                 state_d = ST_LINKED;
          else if (!lock_s)           state_d = ST_RETRY;
          else if (cnt >= UP_LAST)    state_d = ST_RETRY;
        end
        ST_LINKED:    if (!chan_s || !lock_s) state_d = ST_PMA_HOLD;
        ST_RETRY:     state_d = (retry_count == RETRY_MAX) ? ST_FAIL : ST_PMA_HOLD;
        ST_FAIL:      state_d = ST_FAIL;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  // State, shared cycle counter, retry budget and outputs. Outputs are decoded
  // from the next state so they update on the same edge as the state register.
  always_ff @(posedge init_clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt         <= '0;
      retry_count <= 4'd0;
      pma_init    <= 1'b1;
      reset_pb    <= 1'b1;
      link_ok     <= 1'b0;
      link_fail   <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_d != state_q)  cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);

      // A fresh request or a lost link starts a new budget; only a retry
      // out of RETRY consumes one.
      if (state_d == ST_PMA_HOLD && (state_q == ST_IDLE || state_q == ST_LINKED))
        retry_count <= 4'd0;
      else if (state_d == ST_PMA_HOLD && state_q == ST_RETRY)
        retry_count <= retry_count + 4'd1;

      pma_init  <= (state_d == ST_IDLE) || (state_d == ST_PMA_HOLD) || (state_d == ST_FAIL);
      reset_pb  <= (state_d == ST_IDLE) || (state_d == ST_PMA_HOLD) ||
                   (state_d == ST_PB_HOLD) || (state_d == ST_FAIL);
      link_ok   <= (state_d == ST_LINKED);
      link_fail <= (state_d == ST_FAIL);
    end
  end

  assign state = state_q;

`ifdef AURORA_LINK_STATS_EN
  // Counts link losses only; a deliberate enable drop from LINKED goes to
  // IDLE and is not a drop.
  always_ff @(posedge init_clk or posedge reset) begin
    if (reset) begin
      link_drop_count <= 16'd0;
    end else if (state_q == ST_LINKED && state_d == ST_PMA_HOLD &&
                 link_drop_count != 16'hFFFF) begin
      link_drop_count <= link_drop_count + 16'd1;
    end
  end
`endif

endmodule
